// File: rtl/mul_sequencer.sv
// Sequential 32x32 multiplier covering MUL/MULH/MULHSU/MULHU.
// Signed operands become magnitudes and are combined by 32 shift-add steps, then the sign is reapplied.
module mul_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t              state_q, state_d;
    logic                hi_q, hi_d;
    logic                neg_q, neg_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN:0]       mplier_q, mplier_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [5:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     res_q, res_d;

    logic                s1, s2;
    logic [XLEN:0]       mag1, mag2;
    logic [2*XLEN-1:0]   prod;

    always_comb begin
        // MULHU treats rs1 as unsigned; only MUL and MULH treat rs2 as signed.
        s1   = (op != 2'b11);
        s2   = (op == 2'b00) || (op == 2'b01);
        // 33-bit magnitudes keep -2^31 exact after negation.
        mag1 = (s1 && rs1[XLEN-1]) ? -{1'b1, rs1} : {1'b0, rs1};
        mag2 = (s2 && rs2[XLEN-1]) ? -{1'b1, rs2} : {1'b0, rs2};
        prod = neg_q ? -acc_q : acc_q;

        state_d  = state_q;
        hi_d     = hi_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        res_d    = res_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d  = CALC;
                    hi_d     = (op != 2'b00);
                    neg_d    = (s1 & rs1[XLEN-1]) ^ (s2 & rs2[XLEN-1]);
                    mcand_d  = {{(XLEN-1){1'b0}}, mag1};
                    mplier_d = mag2;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            CALC: begin
                if (cnt_q == 6'd32) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    res_d   = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
                end else begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 6'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            hi_q     <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res_q    <= res_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign res  = res_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: the driver queues expected results and cycles, the monitor checks each done pulse.
module tb_mul_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy, done;
    logic [31:0] res;

    mul_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .res(res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          tests = 0;
    int          errs = 0;
    logic [31:0] last_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && q.size() > 0 && cyc > q[0].acc && cyc <= q[0].cyc)
                chk("busy_in_flight", {31'b0, busy}, 32'd1);
            if (!reset && done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("res", res, e.res);
                    chk("latency", cyc, e.cyc);
                    last_exp = e.res;
                end
            end
        end
    end

    task automatic wait_idle(output int m);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
        m = cyc;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input int m);
        exp_t e;
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        e.res = r; e.acc = m + 1; e.cyc = m + 34;
        q.push_back(e);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r);
        int m;
        wait_idle(m);
        chk("res_hold", res, last_exp);
        issue(o, a, b, r, m);
        @(negedge clk);
        start = 1'b0;
        rs1 = $urandom; rs2 = $urandom; op = 2'($urandom);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) chk("done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int m, prev;
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_res", res, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        do_op(2'b00, 32'd3,        32'hFFFFFFFB, 32'hFFFFFFF1);
        do_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
        do_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        do_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_op(2'b01, 32'hFFFFFFFF, 32'h00000000, 32'h00000000);
        do_op(2'b00, 32'h80000000, 32'h80000000, 32'h00000000);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        do_op(2'b00, 32'd7,        32'd6,        32'h0000002A);
        do_op(2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF);
        do_op(2'b01, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000);
        do_op(2'b11, 32'h80000000, 32'd2,        32'h00000001);
        do_op(2'b00, 32'h00000000, 32'h12345678, 32'h00000000);
        drain();

        // start re-pulsed with fresh operands for the whole operation, including the FIN cycle
        wait_idle(m);
        issue(2'b00, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFF1, m);
        repeat (34) begin
            @(negedge clk);
            rs1 = $urandom; rs2 = $urandom; op = 2'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        chk("idle_after_fin", {31'b0, busy}, 32'd0);
        drain();

        // reset at CALC cycle 10 aborts without a done pulse
        wait_idle(m);
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, m);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        q.delete();
        last_exp = '0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_res", res, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        do_op(2'b11, 32'h00010000, 32'h00010000, 32'h00000001);
        drain();

        // start held high: one operation accepted every 35 cycles
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            wait_idle(m);
            if (i > 0) chk("b2b_period", m - prev, 32'd35);
            prev = m;
            case (i)
                0: issue(2'b00, 32'd7, 32'd6, 32'h0000002A, m);
                1: issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, m);
                default: issue(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, m);
            endcase
        end
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("final_res_hold", res, last_exp);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
